// File: rtl/booth_pp_accum_pkg.sv
// -----------------------------------------------------------------------------
// booth_pp_accum_pkg
// Shared constants and the FSM state type for the radix-4 Booth
// partial-product accumulator.
//   NPP     : number of radix-4 partial products (digits)
//   PPW     : partial-product width in bits
//   ACC_W   : accumulator width (product is the low 64 bits)
//   MCAND_W : multiplicand width as presented (already sign/zero extended)
// -----------------------------------------------------------------------------
package booth_pp_accum_pkg;

    localparam int NPP     = 17;
    localparam int PPW     = 35;
    localparam int ACC_W   = 66;
    localparam int MCAND_W = 33;
    localparam int PROD_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : booth_pp_accum_pkg

// File: rtl/booth_pp_sel.sv
// -----------------------------------------------------------------------------
// booth_pp_sel
// Combinational partial-product selector for one radix-4 Booth digit.
// Ports:
//   mcand : 33-bit multiplicand (sign- or zero-extended by the source)
//   set0  : digit is zero (wins over inv, so an illegal set0+inv gives 0)
//   inv   : digit is negative
//   x2    : digit magnitude is 2
//   pp    : PPW-bit two's-complement partial product
// -----------------------------------------------------------------------------
module booth_pp_sel #(
    parameter int PPW = booth_pp_accum_pkg::PPW
) (
    input  logic [32:0]    mcand,
    input  logic           set0,
    input  logic           inv,
    input  logic           x2,
    output logic [PPW-1:0] pp
);
    import booth_pp_accum_pkg::*;

    logic [PPW-1:0] mag;

    always_comb begin
        mag = '0;
        if (!set0) begin
            if (x2) begin
                mag = {{(PPW-MCAND_W-1){mcand[MCAND_W-1]}}, mcand, 1'b0};
            end else begin
                mag = {{(PPW-MCAND_W){mcand[MCAND_W-1]}}, mcand};
            end
        end
        // Negation is gated by set0 explicitly so a zero digit can never
        // turn into anything but zero, whatever inv says.
        pp = (inv && !set0) ? (~mag + PPW'(1)) : mag;
    end

endmodule : booth_pp_sel

// File: rtl/booth_pp_accum.sv
// -----------------------------------------------------------------------------
// booth_pp_accum
// Sequential radix-4 Booth multiplier back end: latches a job (multiplicand
// plus per-digit Booth controls), adds one shifted partial product per cycle
// into a 66-bit accumulator, and presents the low 64 bits with a
// valid/ready handshake.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : job handshake (accept when both high)
//   mcand               : 33-bit multiplicand
//   set0, inv, X2       : per-digit Booth controls (NPP bits each)
//   flush               : abort any job, return to IDLE next edge
//   out_valid/out_ready : result handshake
//   product             : 64-bit result, held stable while out_valid
// -----------------------------------------------------------------------------
module booth_pp_accum #(
    parameter int NPP = booth_pp_accum_pkg::NPP,
    parameter int PPW = booth_pp_accum_pkg::PPW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [32:0]    mcand,
    input  logic [NPP-1:0] set0,
    input  logic [NPP-1:0] inv,
    input  logic [NPP-1:0] X2,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [63:0]    product
);
    import booth_pp_accum_pkg::*;

    localparam int CNT_W = $clog2(NPP);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [32:0]        mcand_q, mcand_d;
    logic [NPP-1:0]     set0_q, set0_d;
    logic [NPP-1:0]     inv_q, inv_d;
    logic [NPP-1:0]     x2_q, x2_d;

    logic [PPW-1:0]     pp;
    logic [ACC_W-1:0]   pp_ext;
    logic [ACC_W-1:0]   pp_shift;

    booth_pp_sel #(
        .PPW (PPW)
    ) u_sel (
        .mcand (mcand_q),
        .set0  (set0_q[cnt_q]),
        .inv   (inv_q[cnt_q]),
        .x2    (x2_q[cnt_q]),
        .pp    (pp)
    );

    // Digit cnt carries weight 4^cnt, i.e. a left shift of 2*cnt.
    assign pp_ext   = {{(ACC_W-PPW){pp[PPW-1]}}, pp};
    assign pp_shift = pp_ext << {cnt_q, 1'b0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        set0_d  = set0_q;
        inv_d   = inv_q;
        x2_d    = x2_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    mcand_d = mcand;
                    set0_d  = set0;
                    inv_d   = inv;
                    x2_d    = X2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_q + pp_shift;
                if (cnt_q == CNT_W'(NPP-1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything, including a coincident accept.
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            set0_q  <= '0;
            inv_q   <= '0;
            x2_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            set0_q  <= set0_d;
            inv_q   <= inv_d;
            x2_q    <= x2_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !flush && !rst;
    assign out_valid = (state_q == DONE);
    // Zero outside DONE so reset and flush give a clean all-zero output.
    assign product   = out_valid ? acc_q[63:0] : 64'd0;

endmodule : booth_pp_accum

// File: doc/booth_pp_accum.md
BOOTH_PP_ACCUM -- requirements
Module: booth_pp_accum

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: a multiply job is presented.
REQ-004 SHALL have port in_ready, output, 1 bit: the block can accept a job this cycle.
REQ-005 SHALL have port mcand, input, 33 bits: multiplicand, sign- or zero-extended to 33 bits by the source.
REQ-006 SHALL have port set0, input, 17 bits: Booth digit i is zero.
REQ-007 SHALL have port inv, input, 17 bits: Booth digit i is negative.
REQ-008 SHALL have port X2, input, 17 bits: Booth digit i has magnitude 2.
REQ-009 SHALL have port flush, input, 1 bit: abort any job in progress.
REQ-010 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the product.
REQ-012 SHALL have port product, output, 64 bits: the multiply result.
REQ-013 SHALL have parameter NPP, default 17: number of radix-4 partial products.
REQ-014 SHALL have parameter PPW, default 35: partial-product width in bits.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with flush=0; a job is accepted on an edge where in_valid and in_ready are both 1.
REQ-017 On accept, SHALL register mcand, set0, inv and X2, clear the 66-bit accumulator acc, clear the digit counter cnt, and go to BUSY.
REQ-018 In BUSY, each cycle SHALL add one partial product: mag = 0 if set0[cnt]; else 2*mcand if X2[cnt]; else mcand (sign-extended to PPW).
REQ-019 The value added SHALL be pp = (inv[cnt] ? ~mag + 1 : mag), sign-extended to 66 bits and shifted left by 2*cnt, with acc updated modulo 2^66.
REQ-020 cnt SHALL increment by 1 per BUSY cycle; the cycle with cnt = NPP-1 SHALL perform the last add and go to DONE.
REQ-021 Latency SHALL be fixed: out_valid rises exactly NPP = 17 edges after the accept edge.
REQ-022 In DONE, out_valid SHALL be 1, product SHALL equal acc[63:0], and product SHALL hold stable until handshake.
REQ-023 When out_valid and out_ready are both 1, SHALL return to IDLE; a new job is not accepted in that same cycle.
REQ-024 Throughput SHALL be at most one job per 19 cycles.
REQ-025 Whenever flush = 1, SHALL go to IDLE on the next edge and discard acc; out_valid SHALL be 0 from that edge on.
REQ-026 When flush and accept conditions coincide, flush SHALL take priority and the job SHALL NOT be accepted.
REQ-027 When set0[i] and inv[i] are both 1 (illegal encoding), set0 SHALL take priority and the term SHALL contribute 0.
REQ-028 Registered inputs SHALL be ignored outside the accept edge.

Reset
REQ-029 While rst = 1, SHALL enter IDLE with cnt=0, acc=0, out_valid=0, product=0 and in_ready=0.
REQ-030 rst SHALL override flush, in_valid and out_ready, including when asserted mid-BUSY or in DONE.
REQ-031 The first accept SHALL be possible on the edge after rst deasserts.

Structure
REQ-032 A shared package SHALL hold NPP, PPW, the accumulator width 66, and the FSM state enumeration.
REQ-033 The single sub-module booth_pp_sel SHALL be combinational: (mcand, set0, inv, X2 bit) -> PPW-bit pp.
REQ-034 The accumulator, counter and FSM SHALL reside in booth_pp_accum.

Verification
REQ-035 Controls from a radix-4 encoding of multiplier 3, mcand=5 -> product 0x000000000000000F at accept+17.
REQ-036 Signed: multiplier -1, mcand=-1 (33-bit all ones) -> product 0x0000000000000001.
REQ-037 Signed: multiplier 0x80000000, mcand 0x80000000 (both sign-extended) -> product 0x4000000000000000; unsigned: 0xFFFFFFFF x 0xFFFFFFFF zero-extended -> 0xFFFFFFFE00000001.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> product stable, in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-039 flush at cnt=8 -> IDLE next edge, no out_valid; a following job 7x9 -> product 63.
REQ-040 rst during BUSY -> all outputs 0 next edge; flush asserted with in_valid in IDLE -> job not accepted.
